// File: rtl/uart_rx_fifo.sv
// Receive FIFO between a UART receiver and the CPU: first-word fall-through, sticky overrun flag.
// Optional level interrupt o_irq is built only when UART_RX_FIFO_IRQ_EN is defined.
module uart_rx_fifo #(
  parameter int Depth        = 16,
  parameter int IrqThreshold = 8,
  localparam int PtrW        = $clog2(Depth),
  localparam int CntW        = $clog2(Depth + 1)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_in_valid,
  output logic            o_in_ready,
  input  logic [7:0]      i_in_bits,
  input  logic            i_rx_overrun,
  output logic            o_out_valid,
  input  logic            i_out_ready,
  output logic [7:0]      o_out_bits,
  output logic [CntW-1:0] o_count,
  output logic            o_overrun,
  input  logic            i_clear
`ifdef UART_RX_FIFO_IRQ_EN
  ,
  output logic            o_irq
`endif
);

  localparam logic [CntW-1:0] FullCount = CntW'(Depth);

  if (Depth < 2 || Depth > 256 || (Depth & (Depth - 1)) != 0) begin : g_bad_depth
    $error("uart_rx_fifo: Depth must be a power of two in 2..256");
  end
  if (IrqThreshold < 1 || IrqThreshold > Depth) begin : g_bad_threshold
    $error("uart_rx_fifo: IrqThreshold must be in 1..Depth");
  end

  logic [7:0]      storage_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            overrun_q, overrun_d;
  logic            push, pop;

  // Handshakes depend only on registered occupancy, so in_ready never sees out_ready.
  assign o_in_ready  = (count_q != FullCount);
  assign o_out_valid = (count_q != '0);
  assign o_out_bits  = storage_q[rd_ptr_q];
  assign o_count     = count_q;
  assign o_overrun   = overrun_q;

  assign push = i_in_valid && o_in_ready;
  assign pop  = o_out_valid && i_out_ready;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = overrun_q | i_rx_overrun;
    if (i_clear) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      overrun_d = 1'b0;
    end else begin
      wr_ptr_d = wr_ptr_q + PtrW'(push);
      rd_ptr_d = rd_ptr_q + PtrW'(pop);
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  // Data array carries no reset; stale entries are hidden while count is zero.
  always_ff @(posedge i_clk) begin
    if (push && !i_clear) begin
      storage_q[wr_ptr_q] <= i_in_bits;
    end
  end

`ifdef UART_RX_FIFO_IRQ_EN
  logic irq_q, irq_d;

  always_comb begin
    irq_d = (int'(count_d) >= IrqThreshold) || overrun_d;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign o_irq = irq_q;
`endif

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter Depth, default 16, FIFO entries; power of two, 2..256.
REQ-002 SHALL have parameter IrqThreshold, default 8, level at which o_irq asserts; range 1..Depth.
REQ-003 SHALL have port i_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port i_rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port i_in_valid  input  1  received byte valid, from the UART receiver's Decoupled sender.
REQ-006 SHALL have port o_in_ready  output  1  FIFO can accept a byte.
REQ-007 SHALL have port i_in_bits  input  8  received byte.
REQ-008 SHALL have port i_rx_overrun  input  1  receiver overrun indication.
REQ-009 SHALL have port o_out_valid  output  1  head byte available to the CPU.
REQ-010 SHALL have port i_out_ready  input  1  CPU consumes the head byte.
REQ-011 SHALL have port o_out_bits  output  8  head byte.
REQ-012 SHALL have port o_count  output  $clog2(Depth+1)  current occupancy.
REQ-013 SHALL have port o_overrun  output  1  sticky overrun flag.
REQ-014 SHALL have port i_clear  input  1  synchronous flush.
REQ-015 SHALL have port o_irq  output  1  level interrupt; present only under REQ-034.

Function
REQ-016 SHALL push i_in_bits when i_in_valid && o_in_ready at a rising edge.
REQ-017 SHALL pop the head when o_out_valid && i_out_ready at a rising edge.
REQ-018 SHALL drive o_in_ready = (count != Depth), derived only from registered state; there SHALL be no combinational path from i_out_ready to o_in_ready.
REQ-019 SHALL drive o_out_valid = (count != 0) and o_out_bits = storage[rd_ptr] (first-word fall-through).
REQ-020 SHALL provide latency of exactly one cycle: a byte pushed at edge N has o_out_valid high after edge N.
REQ-021 SHALL, on simultaneous push and pop with 0 < count < Depth, leave count unchanged and advance both pointers.
REQ-022 SHALL, when full, refuse the push (o_in_ready=0) even if a pop occurs in the same cycle; the upstream holds its byte until the next cycle.
REQ-023 SHALL, when empty, perform no pop; a same-cycle push only increments count.
REQ-024 SHALL keep pointers $clog2(Depth) bits wide, wrapping naturally from Depth-1 to 0.
REQ-025 SHALL update count as count + push - pop; count SHALL never exceed Depth or go below 0.
REQ-026 SHALL set o_overrun at the edge where i_rx_overrun=1 and hold it until i_clear or reset.
REQ-027 SHALL, when i_clear=1, zero count, rd_ptr, wr_ptr and o_overrun, with priority over a same-cycle push, pop or i_rx_overrun.
REQ-028 SHALL leave storage contents uninitialised and never observable while count=0.
REQ-029 SHALL preserve byte order exactly (FIFO).

Reset
REQ-030 SHALL, on i_rst_n low, asynchronously clear count, rd_ptr, wr_ptr, o_overrun and the irq register.
REQ-031 SHALL present these outputs during and after reset: o_out_valid=0, o_in_ready=1, o_count=0, o_overrun=0, o_irq=0, o_out_bits=don't-care.
REQ-032 SHALL discard all contents when reset asserts mid-operation; no partial push or pop SHALL survive.
REQ-033 SHALL release reset synchronously to i_clk externally; the block SHALL NOT contain a reset synchroniser.

Configuration
REQ-034 SHALL, with macro UART_RX_FIFO_IRQ_EN defined, provide o_irq as a register equal to (next count >= IrqThreshold) || next o_overrun, updated each edge.
REQ-035 SHALL, with UART_RX_FIFO_IRQ_EN undefined, omit the o_irq port and its register entirely; the IrqThreshold parameter SHALL remain but be unused.

Verification
REQ-036 SHALL cover push-to-visible latency: push 0x41 into an empty FIFO -> o_out_valid=1, o_out_bits=0x41, o_count=1 one cycle later.
REQ-037 SHALL cover fill and wrap-around: push 0x00..0x0F with out_ready=0 -> o_in_ready=0, o_count=16; then pop all -> bytes return 0x00..0x0F in order; repeat with 24 bytes interleaved so the pointers wrap.
REQ-038 SHALL cover full with simultaneous pop: at count=16, drive in_valid and out_ready together -> pop occurs, push refused, count=15; the push is accepted on the next cycle and count=16.
REQ-039 SHALL cover overrun and clear priority: pulse i_rx_overrun -> o_overrun=1 and stays set; assert i_clear together with a push and i_rx_overrun -> count=0, o_overrun=0.
REQ-040 SHALL cover reset mid-stream: with count=5, drop i_rst_n between clock edges -> o_count=0 and o_out_valid=0 immediately, o_in_ready=1.
REQ-041 SHALL cover the IRQ threshold with UART_RX_FIFO_IRQ_EN defined: push 8 bytes -> o_irq rises with o_count=8; pop one -> o_irq falls.
